// File: rtl/sprite_pkg.sv
// Shared encodings and default geometry for the multi-sprite motion engine.
package sprite_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'b00,
        MODE_WRAP    = 2'b01,
        MODE_CLAMP   = 2'b10,
        MODE_GRAVITY = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_e;

    localparam int DEF_NUM_SPRITES = 4;
    localparam int DEF_COORD_W     = 10;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_SPR_W       = 40;
    localparam int DEF_SPR_H       = 40;
    localparam int DEF_TICK_DIV    = 500000;
    localparam int DEF_GRAVITY     = 1;
    localparam int DEF_VEL_MAX     = 8;
    localparam int DEF_IMPULSE     = -6;

    // Sprite index width; a single sprite still needs one bit of id port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_engine_tick_gen.sv
// Free-running divider producing a one-cycle motion enable every TICK_DIV clocks.
module tick_gen
    import sprite_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;

    // Next count value with wrap at the last phase.
    always_comb begin
        if (cnt_r == LAST) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Counter and registered strobe, high exactly while the count sits at LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            tick  <= (cnt_nxt_s == LAST);
        end
    end

endmodule

// File: rtl/sprite_engine.sv
// NUM_SPRITES vertical movers with per-sprite motion mode and a registered pixel hit test.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int SPR_W       = DEF_SPR_W,
    parameter int SPR_H       = DEF_SPR_H,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int GRAVITY     = DEF_GRAVITY,
    parameter int VEL_MAX     = DEF_VEL_MAX,
    parameter int IMPULSE     = DEF_IMPULSE,
    parameter int ID_W        = id_width(NUM_SPRITES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COORD_W-1:0]     i_x,
    input  logic [COORD_W-1:0]     i_y,
    input  logic [NUM_SPRITES-1:0] i_impulse,
    input  logic                   i_cfg_valid,
    output logic                   o_cfg_ready,
    input  logic [ID_W-1:0]        i_cfg_id,
    input  logic [COORD_W-1:0]     i_cfg_col,
    input  logic [COORD_W-1:0]     i_cfg_top,
    input  logic signed [7:0]      i_cfg_vel,
    input  logic [1:0]             i_cfg_mode,
    output logic [NUM_SPRITES-1:0] o_hit,
    output logic                   o_any,
    output logic [ID_W-1:0]        o_hit_id,
    output logic [NUM_SPRITES-1:0] o_at_floor,
    output logic                   o_tick
);

    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] SH_S    = SW'(SCREEN_H);
    localparam logic signed [SW-1:0] MAXT_S  = SW'(SCREEN_H - SPR_H);
    localparam logic signed [8:0]    VMAX_S  = 9'(VEL_MAX);
    localparam logic signed [8:0]    GRAV_S  = 9'(GRAVITY);
    localparam logic signed [7:0]    IMP_V   = 8'(IMPULSE);
    localparam logic [ID_W-1:0]      LAST_ID = ID_W'(NUM_SPRITES - 1);
    localparam logic [COORD_W:0]     SPRW_E  = (COORD_W+1)'(SPR_W);
    localparam logic [COORD_W:0]     SPRH_E  = (COORD_W+1)'(SPR_H);

    logic [COORD_W-1:0]     col_r  [NUM_SPRITES];
    logic [COORD_W-1:0]     top_r  [NUM_SPRITES];
    logic signed [7:0]      vel_r  [NUM_SPRITES];
    mode_e                  mode_r [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] imp_pend_r;
    state_e                 state_r;
    logic [ID_W-1:0]        idx_r;

    logic                   cfg_acc_s;
    logic                   upd_en_s;
    logic [COORD_W-1:0]     sel_top_s;
    logic signed [7:0]      sel_vel_s;
    mode_e                  sel_mode_s;
    logic                   sel_imp_s;
    logic                   sel_floor_s;
    logic signed [8:0]      vg_s;
    logic signed [7:0]      v_s;
    logic signed [SW-1:0]   nt_s;
    logic signed [SW-1:0]   wrap_hi_s;
    logic signed [SW-1:0]   wrap_lo_s;
    logic [COORD_W-1:0]     new_top_s;
    logic signed [7:0]      new_vel_s;
    logic                   new_floor_s;
    logic [NUM_SPRITES-1:0] hit_s;
    logic [ID_W-1:0]        hit_id_s;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (o_tick)
    );

    assign o_cfg_ready = (state_r == ST_IDLE) && !o_tick;
    assign cfg_acc_s   = i_cfg_valid && o_cfg_ready;
    assign upd_en_s    = (state_r == ST_UPDATE);

    // Next-state arithmetic for the sprite currently in its update slot.
    always_comb begin
        sel_top_s   = top_r[idx_r];
        sel_vel_s   = vel_r[idx_r];
        sel_mode_s  = mode_r[idx_r];
        sel_imp_s   = imp_pend_r[idx_r] | i_impulse[idx_r];
        sel_floor_s = o_at_floor[idx_r];
        vg_s        = $signed({sel_vel_s[7], sel_vel_s}) + GRAV_S;
        if (sel_mode_s == MODE_GRAVITY) begin
            if (sel_imp_s) begin
                v_s = IMP_V;
            end else if (vg_s > VMAX_S) begin
                v_s = VMAX_S[7:0];
            end else begin
                v_s = vg_s[7:0];
            end
        end else begin
            v_s = sel_vel_s;
        end
        nt_s        = $signed({2'b00, sel_top_s}) + $signed({{(SW-8){v_s[7]}}, v_s});
        wrap_hi_s   = nt_s - SH_S;
        wrap_lo_s   = nt_s + SH_S;
        new_top_s   = sel_top_s;
        new_vel_s   = sel_vel_s;
        new_floor_s = sel_floor_s;
        case (sel_mode_s)
            MODE_WRAP: begin
                if (nt_s >= SH_S) begin
                    new_top_s = wrap_hi_s[COORD_W-1:0];
                end else if (nt_s[SW-1]) begin
                    new_top_s = wrap_lo_s[COORD_W-1:0];
                end else begin
                    new_top_s = nt_s[COORD_W-1:0];
                end
            end
            MODE_CLAMP: begin
                if (nt_s[SW-1]) begin
                    new_top_s   = '0;
                    new_floor_s = 1'b0;
                end else if (nt_s >= MAXT_S) begin
                    new_top_s   = MAXT_S[COORD_W-1:0];
                    new_floor_s = 1'b1;
                end else begin
                    new_top_s   = nt_s[COORD_W-1:0];
                    new_floor_s = 1'b0;
                end
            end
            MODE_GRAVITY: begin
                if (nt_s[SW-1]) begin
                    new_top_s   = '0;
                    new_vel_s   = 8'sd0;
                    new_floor_s = 1'b0;
                end else if (nt_s >= MAXT_S) begin
                    new_top_s   = MAXT_S[COORD_W-1:0];
                    new_vel_s   = 8'sd0;
                    new_floor_s = 1'b1;
                end else begin
                    new_top_s   = nt_s[COORD_W-1:0];
                    new_vel_s   = v_s;
                    new_floor_s = 1'b0;
                end
            end
            default: begin
                new_top_s = sel_top_s;
            end
        endcase
    end

    // Per-sprite state: config writes win over impulses; update slot consumes imp_pend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                col_r[i]  <= '0;
                top_r[i]  <= '0;
                vel_r[i]  <= 8'sd0;
                mode_r[i] <= MODE_STATIC;
            end
            imp_pend_r <= '0;
            o_at_floor <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (cfg_acc_s && (i_cfg_id == ID_W'(i))) begin
                    col_r[i]      <= i_cfg_col;
                    top_r[i]      <= i_cfg_top;
                    vel_r[i]      <= i_cfg_vel;
                    mode_r[i]     <= mode_e'(i_cfg_mode);
                    imp_pend_r[i] <= 1'b0;
                    o_at_floor[i] <= 1'b0;
                end else if (upd_en_s && (idx_r == ID_W'(i))) begin
                    top_r[i]      <= new_top_s;
                    vel_r[i]      <= new_vel_s;
                    o_at_floor[i] <= new_floor_s;
                    imp_pend_r[i] <= 1'b0;
                end else if (i_impulse[i]) begin
                    imp_pend_r[i] <= 1'b1;
                end
            end
        end
    end

    // Sweep FSM: one sprite per cycle after each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (o_tick) begin
                        state_r <= ST_UPDATE;
                        idx_r   <= '0;
                    end
                end
                ST_UPDATE: begin
                    if (idx_r == LAST_ID) begin
                        state_r <= ST_IDLE;
                    end else begin
                        idx_r <= idx_r + ID_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= '0;
                end
            endcase
        end
    end

    // Box test widened by one bit so col+SPR_W and top+SPR_H never wrap.
    always_comb begin
        hit_s    = '0;
        hit_id_s = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit_s[i] = ({1'b0, i_x} >= {1'b0, col_r[i]}) &&
                       ({1'b0, i_x} <  ({1'b0, col_r[i]} + SPRW_E)) &&
                       ({1'b0, i_y} >= {1'b0, top_r[i]}) &&
                       ({1'b0, i_y} <  ({1'b0, top_r[i]} + SPRH_E));
        end
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            hit_id_s = hit_s[i] ? ID_W'(i) : hit_id_s;
        end
    end

    // Registered hit outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hit    <= '0;
            o_any    <= 1'b0;
            o_hit_id <= '0;
        end else begin
            o_hit    <= hit_s;
            o_any    <= |hit_s;
            o_hit_id <= hit_id_s;
        end
    end

endmodule

// File: doc/sprite_engine.md
# sprite_engine

Parametrised multi-sprite motion and pixel-hit engine for the Flappy Bird display path. It generalises the hard-coded bird and scroller squares to NUM_SPRITES independently configurable vertical movers. Each mover has a selectable motion mode: static, wrap, clamp, or gravity with flap impulse. The block sits between the keyboard/velocity front end and the VGA colour mux, consuming vga_timing pixel coordinates. All motion runs on one clock with a tick enable, with no derived clocks.

## Interface
- NUM_SPRITES, 4: number of sprites, 1..16
- COORD_W, 10: coordinate width
- SCREEN_H, 480: visible lines
- SPR_W, 40: sprite width in pixels
- SPR_H, 40: sprite height in pixels
- TICK_DIV, 500000: clk cycles per motion tick; must be ≥ NUM_SPRITES+2
- GRAVITY, 1: velocity increment per tick in gravity mode
- VEL_MAX, 8: positive (downward) velocity limit
- IMPULSE, -6: velocity loaded on flap
- clk  in  1  board clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- i_x, i_y  in  COORD_W each  current pixel coordinates
- i_impulse  in  NUM_SPRITES  one-cycle flap pulse per sprite
- i_cfg_valid  in  1  config write request
- o_cfg_ready  out  1  config write accepted when high with valid
- i_cfg_id  in  clog2(NUM_SPRITES)  target sprite
- i_cfg_col  in  COORD_W  sprite left x
- i_cfg_top  in  COORD_W  sprite top y
- i_cfg_vel  in  8 signed  initial velocity, lines/tick
- i_cfg_mode  in  2  00 STATIC, 01 WRAP, 10 CLAMP, 11 GRAVITY
- o_hit  out  NUM_SPRITES  pixel inside sprite i
- o_any  out  1  OR of o_hit
- o_hit_id  out  clog2(NUM_SPRITES)  lowest index hit; 0 if none
- o_at_floor  out  NUM_SPRITES  sprite resting at bottom clamp
- o_tick  out  1  motion tick strobe

## Operation
- Per-sprite registers: col, top, vel (8b signed), mode, imp_pend. Reset value of all is 0, so every sprite starts STATIC at (0,0). All outputs reset to 0.
- Tick counter runs 0..TICK_DIV-1 and wraps. o_tick is high during the cycle in which the count equals TICK_DIV-1.
- FSM has two states, IDLE and UPDATE.
  - IDLE→UPDATE on o_tick, with idx=0.
  - UPDATE processes sprite idx in one cycle, then idx++.
  - UPDATE→IDLE after idx=NUM_SPRITES-1.
- o_cfg_ready = (state==IDLE) && !o_tick. An accepted write loads col, top, vel and mode. It also clears imp_pend[id] and o_at_floor[id].
- i_impulse[i] sets imp_pend[i]. If that sprite is in its update slot in the same cycle, the impulse is applied in that update. An impulse coinciding with an accepted config write to the same sprite is dropped.
- Update arithmetic is done in COORD_W+2 signed bits: nt = top + v.
  - STATIC: no change.
  - WRAP: v=vel. If nt ≥ SCREEN_H, top = nt-SCREEN_H. If nt < 0, top = nt+SCREEN_H.
  - CLAMP: v=vel. top = clamp(nt, 0, SCREEN_H-SPR_H). at_floor = (top at the upper bound).
  - GRAVITY: v = IMPULSE if imp_pend, else min(vel+GRAVITY, VEL_MAX); store vel=v. Clamp top as in CLAMP. When clamped at the bottom, vel=0 and at_floor=1. When clamped at 0, vel=0. at_floor clears when top moves off the floor.
  - imp_pend clears on that sprite's update slot, in every mode.
- Hit test: hit[i] = col ≤ i_x < col+SPR_W and top ≤ i_y < top+SPR_H. Use unsigned compares widened by 1 bit so col+SPR_W does not overflow.
- Position changes mid-frame are allowed. The hit test always uses the current registers.

## Timing
- Tick at cycle T: sprite i updates at the clk edge ending cycle T+1+i. FSM is back in IDLE at T+1+NUM_SPRITES.
- o_hit, o_any and o_hit_id are registered: 1 cycle latency from i_x/i_y.
- A config write takes effect on the next edge; hit outputs reflect it one cycle later.
- Reset mid-UPDATE aborts the sweep. The FSM returns to IDLE and the tick counter returns to 0.

## Structure
- Package sprite_pkg holds the mode encodings (MODE_STATIC/WRAP/CLAMP/GRAVITY), the FSM state type, and the default geometry constants.
- Sub-module tick_gen (TICK_DIV): counter that emits a one-cycle enable. It replaces clock_divider-style derived clocks.

## Test plan
- Reset, then TICK_DIV=8, sprite 1 WRAP, top=470, vel=+5 → after tick 1, top=475; after tick 2, top=0.
- Sprite 0 GRAVITY, top=100, vel=0, GRAVITY=1 → tops 101, 103, 106; vel saturates at 8.
- GRAVITY sprite at top=438, vel=8 → top=440, vel=0, o_at_floor[0]=1. An impulse then gives vel=-6, top=434, at_floor=0.
- Sprites 0 and 2 overlap at pixel (310,200) → o_hit=0101, o_any=1, o_hit_id=0, all one cycle after the pixel.
- Hold i_cfg_valid across a tick → o_cfg_ready low for NUM_SPRITES+1 cycles; the write is accepted on the first IDLE cycle.
- Assert rst_n low during UPDATE → all registers and outputs are 0 immediately, and the next tick occurs TICK_DIV cycles after release.
